nes_pad_poller: RTL and testbench
=================================

// Module: nes_pad_poller
// PURPOSE
// - Parametrised serial game-pad poller: drives latch/pulse to CHANNELS pads, shifts BITS bits per pad.
// - Presents decoded, active-high button words plus a one-cycle valid strobe.
// - Sits between pad pins (via input synchronisers) and the game/UI logic.
// - Successor to the fixed 8-bit single-pad shift register: adds poll request, generated pad strobes, multi-pad, atomic output update.
// PARAMETERS
// - CHANNELS      2  number of pads polled in parallel (>=1)
// - BITS          8  bits shifted per pad (8 NES, 12/16 SNES-style) (>=2)
// - LATCH_CYCLES  1  clk cycles latch is held high (>=1)
// - PULSE_CYCLES  1  clk cycles for each pulse high phase and each low phase (>=1)
// PORTS
// - clk      in   1                clock, all state on rising edge
// - reset    in   1                asynchronous, active-high reset
// - start    in   1                poll request, sampled in IDLE only
// - data     in   CHANNELS         serial pad data, active-low, one bit per pad, pre-synchronised
// - latch    out  1                pad latch strobe, shared by all pads
// - pulse    out  1                pad clock strobe, shared by all pads
// - buttons  out  CHANNELS*BITS    pad c bit k at [c*BITS+k], 1 = pressed; bit 0 = first bit shifted
// - pressed  out  CHANNELS*BITS    newly-pressed mask (see CONFIGURATION)
// - valid    out  1                one-cycle strobe, buttons/pressed updated this cycle
// - busy     out  1                high in every state except IDLE
// BEHAVIOUR
// - Reset: state=IDLE; latch, pulse, valid, busy = 0; buttons, pressed, shift regs, counters = 0.
// - Reset mid-poll aborts immediately; no partial word ever reaches buttons; next poll needs a fresh start.
// - FSM states: IDLE, LATCH, SAMPLE, PULSE_HI, PULSE_LO, DONE.
//   IDLE:     start=1 -> LATCH; start=0 -> stay.
//   LATCH:    latch=1 for LATCH_CYCLES cycles -> SAMPLE; bit index k=0.
//   SAMPLE:   one cycle, latch=pulse=0; shift ~data[c] into bit k of channel c's shift reg.
//             k==BITS-1 -> DONE, else -> PULSE_HI.
//   PULSE_HI: pulse=1 for PULSE_CYCLES cycles -> PULSE_LO.
//   PULSE_LO: pulse=0 for PULSE_CYCLES cycles; k<=k+1 -> SAMPLE.
//   DONE:     one cycle; buttons <= shift regs (all channels atomically); valid=1 -> IDLE.
// - latch/pulse/valid/busy are registered, decoded from the state register; never glitch.
// - Exactly BITS-1 pulses per poll; pulse never high while latch is high.
// - valid high in exactly one cycle per completed poll.
//   Latency from start-sampling edge to valid-high cycle = LATCH_CYCLES + BITS + 2*PULSE_CYCLES*(BITS-1) + 1.
//   Defaults give 24 cycles.
// - start while busy: ignored, not queued. start held high: back-to-back polls, IDLE lasts one cycle between polls.
// - buttons hold their value between valid strobes.
// - Sub-counters are sized $clog2 of their max values.
// - k saturates at BITS-1; no wrap inside a poll.
// CONFIGURATION
// - Macro NES_PAD_EDGE_EN.
// - Defined: per-bit register prev <= buttons at DONE.
//   pressed <= new_word & ~prev, updated in the same cycle as buttons (qualified by valid).
//   pressed holds between polls; reset clears prev, so the first poll reports every held button as pressed.
// - Undefined: prev register not built; pressed tied to 0; all other behaviour identical.
// TESTING
// - Defaults; pad0 stream 0,1,1,1,1,1,1,0, pad1 all 1s; start pulse
//   -> valid at start+24, buttons[7:0]=8'h81, buttons[15:8]=8'h00.
// - Count strobes over one poll -> latch high 1 cycle, 7 pulses each 1 hi/1 lo, pulse never with latch.
// - start re-pulsed every cycle while busy -> one valid only, timing unchanged; start held high -> valid every 25 cycles.
// - reset asserted at cycle 10 of a poll -> outputs 0 at once; no valid; buttons stay 0; next poll correct.
// - BITS=12, CHANNELS=4, LATCH_CYCLES=6, PULSE_CYCLES=3
//   -> valid at start+6+12+66+1=85; each pad's 12-bit word matches the driven pattern.
// - NES_PAD_EDGE_EN: poll A held, then A+B -> pressed 8'h01, then 8'h02; same word again -> pressed 0; without macro pressed always 0.

Source files
------------

// File: rtl/nes_pad_poller_if.sv
// Pad poller bus: poll request, serial pad lines, pad strobes and decoded button words.
// Latency: none, wires only.
// Backpressure: none; start is a request that the poller samples only while idle.
// Ports (master = poller side):
//   start   poll request            data    serial pad lines, active-low, one per pad
//   latch   shared pad latch        pulse   shared pad clock
//   buttons decoded words, 1=pressed pressed newly-pressed mask
//   valid   one-cycle update strobe busy    poll in progress
interface nes_pad_poller_if #(
  parameter int CHANNELS = 2,
  parameter int BITS     = 8
);
  logic                     start;
  logic [CHANNELS-1:0]      data;
  logic                     latch;
  logic                     pulse;
  logic [CHANNELS*BITS-1:0] buttons;
  logic [CHANNELS*BITS-1:0] pressed;
  logic                     valid;
  logic                     busy;

  modport master (
    input  start, data,
    output latch, pulse, buttons, pressed, valid, busy
  );

  modport slave (
    output start, data,
    input  latch, pulse, buttons, pressed, valid, busy
  );
endinterface

// File: rtl/nes_pad_poller.sv
// Serial game-pad poller: strobes latch/pulse to CHANNELS pads, shifts BITS bits each, publishes decoded words.
// Latency: start edge to valid = LATCH_CYCLES + BITS + 2*PULSE_CYCLES*(BITS-1) + 1 cycles (24 at defaults).
// Backpressure: none; start is ignored while busy, never queued; held start gives back-to-back polls.
// Ports: clk, reset (async active-high), bus (nes_pad_poller_if.master: start, data in; latch, pulse,
//   buttons, pressed, valid, busy out). Pad c bit k lands at buttons[c*BITS+k]; bit 0 is the first bit shifted.
// Optional feature: define NES_PAD_EDGE_EN to build the newly-pressed mask; otherwise pressed is tied to 0.
module nes_pad_poller #(
  parameter int CHANNELS     = 2,
  parameter int BITS         = 8,
  parameter int LATCH_CYCLES = 1,
  parameter int PULSE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  nes_pad_poller_if.master  bus
);

  localparam int KW = (BITS > 1)         ? $clog2(BITS)         : 1;
  localparam int LW = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
  localparam int PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam int NW = CHANNELS * BITS;

  localparam logic [KW-1:0] K_LAST = KW'(BITS - 1);
  localparam logic [LW-1:0] L_LAST = LW'(LATCH_CYCLES - 1);
  localparam logic [PW-1:0] P_LAST = PW'(PULSE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    SAMPLE,
    PULSE_HI,
    PULSE_LO,
    DONE
  } state_t;

  state_t        state;
  logic [LW-1:0] lcnt;
  logic [PW-1:0] pcnt;
  logic [KW-1:0] k;
  logic [NW-1:0] shreg;
  logic [NW-1:0] sampled;
  logic          last_sample;

  // Shift register with the current bit of every pad merged in. On the final
  // sample this is the complete new word, so buttons can be loaded on the same
  // edge that enters DONE and be visible while valid is high.
  always_comb begin
    sampled = shreg;
    for (int c = 0; c < CHANNELS; c++) begin
      sampled[c*BITS + int'(k)] = ~bus.data[c];
    end
  end

  assign last_sample = (state == SAMPLE) && (k == K_LAST);

  // Outputs are registered and set on the transition into the state that
  // owns them, so they line up exactly with the state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      lcnt        <= '0;
      pcnt        <= '0;
      k           <= '0;
      shreg       <= '0;
      bus.buttons <= '0;
      bus.latch   <= 1'b0;
      bus.pulse   <= 1'b0;
      bus.valid   <= 1'b0;
      bus.busy    <= 1'b0;
    end else begin
      bus.valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state     <= LATCH;
            lcnt      <= '0;
            k         <= '0;
            bus.latch <= 1'b1;
            bus.busy  <= 1'b1;
          end
        end
        LATCH: begin
          if (lcnt == L_LAST) begin
            state     <= SAMPLE;
            k         <= '0;
            bus.latch <= 1'b0;
          end else begin
            lcnt <= lcnt + LW'(1);
          end
        end
        SAMPLE: begin
          shreg <= sampled;
          if (k == K_LAST) begin
            state       <= DONE;
            bus.buttons <= sampled;
            bus.valid   <= 1'b1;
          end else begin
            state     <= PULSE_HI;
            pcnt      <= '0;
            bus.pulse <= 1'b1;
          end
        end
        PULSE_HI: begin
          if (pcnt == P_LAST) begin
            state     <= PULSE_LO;
            pcnt      <= '0;
            bus.pulse <= 1'b0;
          end else begin
            pcnt <= pcnt + PW'(1);
          end
        end
        PULSE_LO: begin
          if (pcnt == P_LAST) begin
            state <= SAMPLE;
            // k never wraps inside a poll
            k     <= (k == K_LAST) ? k : k + KW'(1);
          end else begin
            pcnt <= pcnt + PW'(1);
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          bus.latch <= 1'b0;
          bus.pulse <= 1'b0;
          bus.busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef NES_PAD_EDGE_EN
  logic [NW-1:0] prev;

  // prev starts at 0, so the first poll after reset flags every held button.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev        <= '0;
      bus.pressed <= '0;
    end else if (last_sample) begin
      prev        <= sampled;
      bus.pressed <= sampled & ~prev;
    end
  end
`else
  assign bus.pressed = '0;
`endif

endmodule

// File: tb/tb_nes_pad_poller.sv
module tb_nes_pad_poller;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  nes_pad_poller_if #(.CHANNELS(2), .BITS(8))  ifa ();
  nes_pad_poller_if #(.CHANNELS(4), .BITS(12)) ifb ();

  nes_pad_poller #(.CHANNELS(2), .BITS(8), .LATCH_CYCLES(1), .PULSE_CYCLES(1)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa.master)
  );
  nes_pad_poller #(.CHANNELS(4), .BITS(12), .LATCH_CYCLES(6), .PULSE_CYCLES(3)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb.master)
  );

  int checks = 0;
  int passed = 0;

  // Pad models: raw line level per bit, bit 0 presented after latch, next bit after each pulse rise.
  logic [15:0] pat_a [2];
  logic [15:0] pat_b [4];
  int   ia = 0, ib = 0;
  logic pa_q = 1'b0, pb_q = 1'b0;

  always @(negedge clk) begin
    if (ifa.latch) ia = 0;
    else if (ifa.pulse && !pa_q && ia < 15) ia = ia + 1;
    pa_q = ifa.pulse;
    for (int c = 0; c < 2; c++) ifa.data[c] = pat_a[c][ia];
    if (ifb.latch) ib = 0;
    else if (ifb.pulse && !pb_q && ib < 15) ib = ib + 1;
    pb_q = ifb.pulse;
    for (int c = 0; c < 4; c++) ifb.data[c] = pat_b[c][ib];
  end

  // Per-cycle record of one run; index 1 is the cycle after the start-sampling edge.
  logic        wl [0:255];
  logic        wp [0:255];
  logic        wv [0:255];
  logic        wb [0:255];
  int          vcyc [4];
  int          nvalid;
  logic [47:0] vbtn;
  logic [47:0] vprs;

  task automatic set_start(input int which, input logic v);
    if (which == 0) ifa.start = v;
    else            ifb.start = v;
  endtask

  // mode 0: single start pulse; 1: start every cycle until valid; 2: start held for three polls
  task automatic run(input int which, input int mode, input int n);
    int nv;
    nv = 0;
    for (int i = 0; i < 4; i++) vcyc[i] = -1;
    wl[0] = 1'b0; wp[0] = 1'b0; wv[0] = 1'b0; wb[0] = 1'b0;
    set_start(which, 1'b1);
    @(posedge clk);
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (which == 0) begin
        wl[i] = ifa.latch; wp[i] = ifa.pulse; wv[i] = ifa.valid; wb[i] = ifa.busy;
      end else begin
        wl[i] = ifb.latch; wp[i] = ifb.pulse; wv[i] = ifb.valid; wb[i] = ifb.busy;
      end
      if (wv[i]) begin
        if (nv < 4) vcyc[nv] = i;
        nv++;
        vbtn = (which == 0) ? {32'h0, ifa.buttons} : ifb.buttons;
        vprs = (which == 0) ? {32'h0, ifa.pressed} : ifb.pressed;
      end
      case (mode)
        1:       set_start(which, nv == 0);
        2:       set_start(which, nv < 3);
        default: set_start(which, 1'b0);
      endcase
    end
    set_start(which, 1'b0);
    nvalid = nv;
  endtask

  // Mismatching cycles between the recorded run and the ideal strobe waveform.
  // sel 0 latch, 1 pulse, 2 valid, 3 busy.
  function automatic int wave_err(input int sel, input int l, input int p, input int b, input int n);
    int err, tot, per, pos;
    logic e, g;
    err = 0;
    tot = l + b + 2*p*(b-1) + 1;
    per = 1 + 2*p;
    for (int i = 1; i <= n; i++) begin
      pos = i - l - 1;
      case (sel)
        0:       begin e = (i <= l); g = wl[i]; end
        1:       begin e = (pos >= 0) && (pos < per*(b-1)) && ((pos % per) >= 1) && ((pos % per) <= p); g = wp[i]; end
        2:       begin e = (i == tot); g = wv[i]; end
        default: begin e = (i <= tot); g = wb[i]; end
      endcase
      if (g !== e) err++;
    end
    return err;
  endfunction

  function automatic int count_pulses(input int n);
    int cnt;
    cnt = 0;
    for (int i = 1; i <= n; i++) if (wp[i] && !wp[i-1]) cnt++;
    return cnt;
  endfunction

  function automatic int count_overlap(input int n);
    int cnt;
    cnt = 0;
    for (int i = 1; i <= n; i++) if (wl[i] && wp[i]) cnt++;
    return cnt;
  endfunction

  task automatic test_reset;
    @(negedge clk);
    checks++; if (ifa.latch !== 1'b0) $display("FAIL reset_latch: got %b want 0", ifa.latch); else passed++;
    checks++; if (ifa.pulse !== 1'b0) $display("FAIL reset_pulse: got %b want 0", ifa.pulse); else passed++;
    checks++; if (ifa.valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", ifa.valid); else passed++;
    checks++; if (ifa.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", ifa.busy); else passed++;
    checks++; if (ifa.buttons !== 16'h0) $display("FAIL reset_buttons: got %h want 0000", ifa.buttons); else passed++;
    checks++; if (ifa.pressed !== 16'h0) $display("FAIL reset_pressed: got %h want 0000", ifa.pressed); else passed++;
    checks++; if (ifb.buttons !== 48'h0 || ifb.busy !== 1'b0)
      $display("FAIL reset_wide: got buttons %h busy %b want 0/0", ifb.buttons, ifb.busy); else passed++;
    reset = 1'b0;
  endtask

  task automatic test_basic;
    pat_a[0] = 16'hFF7E;  // stream 0,1,1,1,1,1,1,0
    pat_a[1] = 16'hFFFF;
    run(0, 0, 32);
    checks++; if (vcyc[0] !== 24) $display("FAIL basic_latency: got %0d want 24", vcyc[0]); else passed++;
    checks++; if (nvalid !== 1) $display("FAIL basic_valid_count: got %0d want 1", nvalid); else passed++;
    checks++; if (vbtn[15:0] !== 16'h0081) $display("FAIL basic_buttons: got %h want 0081", vbtn[15:0]); else passed++;
    checks++; if (ifa.buttons !== 16'h0081) $display("FAIL basic_hold: got %h want 0081", ifa.buttons); else passed++;
    checks++; if (ifa.busy !== 1'b0) $display("FAIL basic_idle_busy: got %b want 0", ifa.busy); else passed++;
`ifndef NES_PAD_EDGE_EN
    checks++; if (vprs !== 48'h0) $display("FAIL basic_pressed_off: got %h want 0", vprs); else passed++;
`endif
  endtask

  task automatic test_strobes;
    pat_a[0] = 16'hFF55;
    pat_a[1] = 16'hFF0F;
    run(0, 0, 30);
    checks++; if (wave_err(0, 1, 1, 8, 30) !== 0) $display("FAIL latch_wave: got %0d bad cycles want 0", wave_err(0, 1, 1, 8, 30)); else passed++;
    checks++; if (wave_err(1, 1, 1, 8, 30) !== 0) $display("FAIL pulse_wave: got %0d bad cycles want 0", wave_err(1, 1, 1, 8, 30)); else passed++;
    checks++; if (wave_err(2, 1, 1, 8, 30) !== 0) $display("FAIL valid_wave: got %0d bad cycles want 0", wave_err(2, 1, 1, 8, 30)); else passed++;
    checks++; if (wave_err(3, 1, 1, 8, 30) !== 0) $display("FAIL busy_wave: got %0d bad cycles want 0", wave_err(3, 1, 1, 8, 30)); else passed++;
    checks++; if (count_pulses(30) !== 7) $display("FAIL pulse_count: got %0d want 7", count_pulses(30)); else passed++;
    checks++; if (count_overlap(30) !== 0) $display("FAIL latch_pulse_overlap: got %0d want 0", count_overlap(30)); else passed++;
    checks++; if (vbtn[15:0] !== 16'hF0AA) $display("FAIL strobe_buttons: got %h want f0aa", vbtn[15:0]); else passed++;
  endtask

  task automatic test_back_to_back;
    pat_a[0] = 16'hFF7E;
    pat_a[1] = 16'hFFFF;
    run(0, 1, 40);
    checks++; if (nvalid !== 1) $display("FAIL busy_start_valids: got %0d want 1", nvalid); else passed++;
    checks++; if (vcyc[0] !== 24) $display("FAIL busy_start_latency: got %0d want 24", vcyc[0]); else passed++;
    checks++; if (wb[30] !== 1'b0) $display("FAIL busy_start_queued: got busy %b want 0", wb[30]); else passed++;
    run(0, 2, 80);
    checks++; if (nvalid !== 3) $display("FAIL held_valids: got %0d want 3", nvalid); else passed++;
    checks++; if (vcyc[0] !== 24 || vcyc[1] !== 49 || vcyc[2] !== 74)
      $display("FAIL held_spacing: got %0d,%0d,%0d want 24,49,74", vcyc[0], vcyc[1], vcyc[2]); else passed++;
    checks++; if (wb[25] !== 1'b0 || wb[26] !== 1'b1)
      $display("FAIL held_idle_gap: got busy %b%b want 01", wb[25], wb[26]); else passed++;
    checks++; if (vbtn[15:0] !== 16'h0081) $display("FAIL held_buttons: got %h want 0081", vbtn[15:0]); else passed++;
  endtask

  task automatic test_reset_midpoll;
    int bad;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    pat_a[0] = 16'hFF7E;
    pat_a[1] = 16'hFFFF;
    ifa.start = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      ifa.start = 1'b0;
    end
    reset = 1'b1;
    #1;
    checks++; if ({ifa.latch, ifa.pulse, ifa.valid, ifa.busy} !== 4'b0000)
      $display("FAIL abort_strobes: got %b want 0000", {ifa.latch, ifa.pulse, ifa.valid, ifa.busy}); else passed++;
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ifa.valid !== 1'b0 || ifa.busy !== 1'b0 || ifa.buttons !== 16'h0) bad++;
    end
    checks++; if (bad !== 0) $display("FAIL abort_quiet: got %0d bad cycles want 0", bad); else passed++;
    run(0, 0, 30);
    checks++; if (vcyc[0] !== 24 || vbtn[15:0] !== 16'h0081)
      $display("FAIL abort_next_poll: got cycle %0d buttons %h want 24/0081", vcyc[0], vbtn[15:0]); else passed++;
  endtask

  task automatic test_wide;
    logic [11:0] want [4];
    pat_b[0] = 16'hFA5C;
    pat_b[1] = 16'hF0F0;
    pat_b[2] = 16'hFFFF;
    pat_b[3] = 16'hF001;
    want[0] = 12'h5A3;
    want[1] = 12'hF0F;
    want[2] = 12'h000;
    want[3] = 12'hFFE;
    run(1, 0, 95);
    checks++; if (vcyc[0] !== 85) $display("FAIL wide_latency: got %0d want 85", vcyc[0]); else passed++;
    checks++; if (nvalid !== 1) $display("FAIL wide_valid_count: got %0d want 1", nvalid); else passed++;
    checks++; if (count_pulses(95) !== 11) $display("FAIL wide_pulse_count: got %0d want 11", count_pulses(95)); else passed++;
    checks++; if (wave_err(0, 6, 3, 12, 95) !== 0) $display("FAIL wide_latch_wave: got %0d bad cycles want 0", wave_err(0, 6, 3, 12, 95)); else passed++;
    checks++; if (wave_err(1, 6, 3, 12, 95) !== 0) $display("FAIL wide_pulse_wave: got %0d bad cycles want 0", wave_err(1, 6, 3, 12, 95)); else passed++;
    for (int c = 0; c < 4; c++) begin
      checks++; if (vbtn[c*12 +: 12] !== want[c])
        $display("FAIL wide_pad%0d: got %h want %h", c, vbtn[c*12 +: 12], want[c]); else passed++;
    end
  endtask

  task automatic test_edge;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    pat_a[1] = 16'hFFFF;
    pat_a[0] = 16'hFFFE;  // A held
    run(0, 0, 30);
`ifdef NES_PAD_EDGE_EN
    checks++; if (vprs[15:0] !== 16'h0001) $display("FAIL edge_first: got %h want 0001", vprs[15:0]); else passed++;
`else
    checks++; if (vprs[15:0] !== 16'h0000) $display("FAIL edge_off_first: got %h want 0000", vprs[15:0]); else passed++;
`endif
    pat_a[0] = 16'hFFFC;  // A+B
    run(0, 0, 30);
`ifdef NES_PAD_EDGE_EN
    checks++; if (vprs[15:0] !== 16'h0002) $display("FAIL edge_second: got %h want 0002", vprs[15:0]); else passed++;
    checks++; if (ifa.pressed !== 16'h0002) $display("FAIL edge_hold: got %h want 0002", ifa.pressed); else passed++;
`else
    checks++; if (vprs[15:0] !== 16'h0000) $display("FAIL edge_off_second: got %h want 0000", vprs[15:0]); else passed++;
`endif
    checks++; if (vbtn[15:0] !== 16'h0003) $display("FAIL edge_buttons: got %h want 0003", vbtn[15:0]); else passed++;
    run(0, 0, 30);
    checks++; if (vprs[15:0] !== 16'h0000) $display("FAIL edge_repeat: got %h want 0000", vprs[15:0]); else passed++;
  endtask

  initial begin
    reset = 1'b1;
    ifa.start = 1'b0;
    ifb.start = 1'b0;
    pat_a[0] = 16'hFFFF; pat_a[1] = 16'hFFFF;
    for (int c = 0; c < 4; c++) pat_b[c] = 16'hFFFF;
    repeat (3) @(negedge clk);
    test_reset();
    @(negedge clk);
    test_basic();
    test_strobes();
    test_back_to_back();
    test_reset_midpoll();
    test_wide();
    test_edge();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
